// File: rtl/parity_pkg.sv
// Shared sizing helpers and the per-group parity function for the
// parity-protected register file.
package parity_pkg;

  // Widest data word the parity function accepts; callers zero-extend into it.
  localparam int MAX_DW = 256;

  function automatic int calc_ng(input int dw, input int gw);
    return (dw + gw - 1) / gw;
  endfunction

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // XOR of group g; bits at or above dw are excluded so a partial last group works.
  function automatic logic grp_parity(input logic [MAX_DW-1:0] data, input int g,
                                      input int gw, input int dw);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_DW; i++) begin
      if ((i >= g * gw) && (i < (g + 1) * gw) && (i < dw)) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/parity_protected_regfile_if.sv
// Write/read/error-reporting bus of the parity-protected register file.
interface parity_protected_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4,
  parameter int NG         = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NG-1:0]         inj_mask;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [NG-1:0]         rd_err_grp;
  logic                  rd_err;
  logic [CNT_WIDTH-1:0]  err_count;
  logic                  first_err_vld;
  logic [AW-1:0]         first_err_addr;
  logic                  clr_err;

  modport master (
    output wr_en, wr_addr, wr_data, inj_mask, rd_en, rd_addr, clr_err,
    input  rd_valid, rd_data, rd_err_grp, rd_err, err_count, first_err_vld, first_err_addr
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, inj_mask, rd_en, rd_addr, clr_err,
    output rd_valid, rd_data, rd_err_grp, rd_err, err_count, first_err_vld, first_err_addr
  );
endinterface

// File: rtl/parity_group_gen.sv
// Combinational per-group parity generator; ODD_PARITY inverts every group bit.
module parity_group_gen
  import parity_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  GROUP_WIDTH = 8,
  parameter int  ODD_PARITY  = 0,
  localparam int NG          = calc_ng(DATA_WIDTH, GROUP_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [NG-1:0]         par
);

  logic [MAX_DW-1:0] data_ext_s;
  logic              odd_s;

  assign data_ext_s = MAX_DW'(data);
  assign odd_s      = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

  for (genvar g = 0; g < NG; g++) begin : g_par
    assign par[g] = grp_parity(data_ext_s, g, GROUP_WIDTH, DATA_WIDTH) ^ odd_s;
  end

endmodule

// File: rtl/parity_protected_regfile.sv
// Register file storing per-group parity beside each word, checking it on every
// read and keeping a saturating error count plus a first-error address log.
module parity_protected_regfile
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int GROUP_WIDTH = 8,
  parameter int ODD_PARITY  = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  parity_protected_regfile_if.slave  bus
);

  localparam int AW = calc_aw(DEPTH);
  localparam int NG = calc_ng(DATA_WIDTH, GROUP_WIDTH);
  // Parity of an all-zero word, used to initialise storage.
  localparam logic [NG-1:0] INIT_PAR = (ODD_PARITY != 0) ? {NG{1'b1}} : {NG{1'b0}};

  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [NG-1:0]         par_mem_r  [DEPTH];

  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic [NG-1:0]         wr_par_s;
  logic [NG-1:0]         chk_par_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [NG-1:0]         rd_par_s;
  logic [NG-1:0]         rd_grp_s;
  logic                  log_err_s;

  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [NG-1:0]         rd_err_grp_r;
  logic                  rd_err_r;
  logic [AW-1:0]         rd_addr_r;
  logic [CNT_WIDTH-1:0]  err_count_r;
  logic                  first_err_vld_r;
  logic [AW-1:0]         first_err_addr_r;

  assign wr_in_range_s = (int'(bus.wr_addr) < DEPTH);
  assign rd_in_range_s = (int'(bus.rd_addr) < DEPTH);

  parity_group_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .GROUP_WIDTH (GROUP_WIDTH),
    .ODD_PARITY  (ODD_PARITY)
  ) u_wr_gen (
    .data (bus.wr_data),
    .par  (wr_par_s)
  );

  parity_group_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .GROUP_WIDTH (GROUP_WIDTH),
    .ODD_PARITY  (ODD_PARITY)
  ) u_chk_gen (
    .data (rd_word_s),
    .par  (chk_par_s)
  );

  // Read-side storage lookup; out-of-range addresses see a clean zero word.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    rd_par_s  = INIT_PAR;
    if (rd_in_range_s) begin
      rd_word_s = data_mem_r[bus.rd_addr];
      rd_par_s  = par_mem_r[bus.rd_addr];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
      rd_par_s  = INIT_PAR;
    end
  end

  assign rd_grp_s  = rd_in_range_s ? (chk_par_s ^ rd_par_s) : {NG{1'b0}};
  assign log_err_s = rd_valid_r & rd_err_r;

  // Storage write; a same-cycle read sees the previous contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
        par_mem_r[i]  <= INIT_PAR;
      end
    end else if (bus.wr_en && wr_in_range_s) begin
      data_mem_r[bus.wr_addr] <= bus.wr_data;
      par_mem_r[bus.wr_addr]  <= wr_par_s ^ bus.inj_mask;
    end
  end

  // One-cycle read pipeline; rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r   <= 1'b0;
      rd_data_r    <= {DATA_WIDTH{1'b0}};
      rd_err_grp_r <= {NG{1'b0}};
      rd_err_r     <= 1'b0;
      rd_addr_r    <= {AW{1'b0}};
    end else if (bus.rd_en) begin
      rd_valid_r   <= 1'b1;
      rd_data_r    <= rd_word_s;
      rd_err_grp_r <= rd_grp_s;
      rd_err_r     <= |rd_grp_s;
      rd_addr_r    <= bus.rd_addr;
    end else begin
      rd_valid_r   <= 1'b0;
      rd_err_grp_r <= {NG{1'b0}};
      rd_err_r     <= 1'b0;
    end
  end

  // Error accounting; a clear coinciding with an error restarts the log with that error.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r      <= {CNT_WIDTH{1'b0}};
      first_err_vld_r  <= 1'b0;
      first_err_addr_r <= {AW{1'b0}};
    end else if (bus.clr_err) begin
      err_count_r      <= log_err_s ? CNT_WIDTH'(1'b1) : {CNT_WIDTH{1'b0}};
      first_err_vld_r  <= log_err_s;
      first_err_addr_r <= log_err_s ? rd_addr_r : {AW{1'b0}};
    end else if (log_err_s) begin
      if (err_count_r != {CNT_WIDTH{1'b1}}) begin
        err_count_r <= err_count_r + CNT_WIDTH'(1'b1);
      end
      if (!first_err_vld_r) begin
        first_err_vld_r  <= 1'b1;
        first_err_addr_r <= rd_addr_r;
      end
    end
  end

  assign bus.rd_valid       = rd_valid_r;
  assign bus.rd_data        = rd_data_r;
  assign bus.rd_err_grp     = rd_err_grp_r;
  assign bus.rd_err         = rd_err_r;
  assign bus.err_count      = err_count_r;
  assign bus.first_err_vld  = first_err_vld_r;
  assign bus.first_err_addr = first_err_addr_r;

endmodule
